alp_iter_seq: RTL and testbench
===============================

# alp_iter_seq

Multi-cycle iteration sequencer for the ALP ALU slice array. On a start request it takes over the slice control inputs (`alu_h`, `pass_a_h`, `dmove_h`) and shift-in sources, and steps the slices through N iterations of shift, multiply-step (shift-and-add) or non-restoring divide-step. It uses the slice flag outputs to choose each step's operation. It sits between the microsequencer's ALP control field and the ALP slices. While idle, microcode control passes through unchanged.

## Interface
Parameters:
- `CNT_W`, 6: width of iteration count; maximum count is 2^CNT_W−1.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset_l`  in  1  synchronous, active-low reset.
- `start_h`  in  1  request; sampled only in IDLE.
- `mode_h`  in  2  0=SHL, 1=SHR, 2=MUL, 3=DIV; captured with `start_h`.
- `count_h`  in  CNT_W  iteration count; captured with `start_h`; 0 means no iterations.
- `uc_alu_h`  in  4  microcode ALU opcode, passed through when idle.
- `uc_pass_a_h`, `uc_dmove_h`  in  1 each  microcode controls, passed through when idle.
- `q_lsb_h`  in  1  multiplier LSB from the Q register (MUL).
- `alu_msb_h`  in  1  sign of the current ALU result, i.e. most-significant slice `shl_sout_h` (DIV).
- `alu_h`  out  4  opcode to the slices.
- `pass_a_h`, `dmove_h`  out  1 each  slice controls.
- `shl_fill_h`, `shr_fill_h`  out  1 each  end fills for the outermost slices.
- `q_shift_h`  out  1  shift the Q register this cycle.
- `q_bit_h`  out  1  bit shifted into Q (DIV quotient bit).
- `busy_h`  out  1  sequencer owns the slices.
- `done_h`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, STEP, FIX, DONE. Encoding is free.
- IDLE:
  - outputs are the `uc_*` inputs; `busy_h`=0; fills=0; `q_shift_h`=0.
  - `start_h`=1 captures mode and count.
  - count=0 → DONE; else → STEP.
- STEP, one iteration per cycle, counter decrements each cycle:
  - SHL: `alu_h`=ALU_PASSA_SHL, fill 0.
  - SHR: `alu_h`=ALU_PASSA_SHR, `shr_fill_h`=registered sign from the first cycle (arithmetic shift).
  - MUL: `q_lsb_h`=1 → ALU_ADD_SHR, else ALU_PASSA_SHR. `shr_fill_h`=carry-out of the add. `q_shift_h`=1.
  - DIV: internal sign flag `neg` starts 0. `neg`=0 → ALU_SUB_SHL, else ALU_ADD_SHL. Each cycle `neg`←`alu_msb_h`, `q_bit_h`=~`alu_msb_h`, `q_shift_h`=1.
- Last STEP (counter=1): DIV → FIX; others → DONE.
- FIX (DIV only):
  - `neg`=1 → ALU_ADD (restore remainder); `neg`=0 → ALU_PASSA.
  - `q_shift_h`=0.
  - → DONE.
- DONE:
  - `done_h`=1, `busy_h`=0, outputs pass through.
  - → IDLE.
  - `start_h` is ignored in DONE.
- `pass_a_h`=1 on PASSA opcodes, else 0. `dmove_h`=0 whenever `busy_h`=1.
- `start_h` while busy: ignored, no queueing.

## Timing
- Reset (`reset_l`=0 at an edge): state IDLE, counter 0, `neg` 0, `busy_h` 0, `done_h` 0. Reset mid-operation aborts with no FIX cycle; outputs are microcode pass-through on the next cycle.
- `busy_h` is registered: it rises the cycle after the start edge and stays high for count cycles (count+1 for DIV).
- `done_h` is registered and asserts the cycle after the last STEP or FIX.
- Latency from `start_h` to `done_h`:
  - count+1 cycles for SHL/SHR/MUL.
  - count+2 for DIV.
  - 1 for count=0.
- The opcode is combinational from the current state, `q_lsb_h` (MUL) and the `neg` register (DIV). No combinational path from `alu_msb_h` to `alu_h`.
- Counter is CNT_W bits, decrement only, no wrap: it is never decremented at 0.

## Structure
- Shared ALP package holds:
  - ALU opcode constants: ALU_PASSA=4'h0, ALU_ADD=4'h4, ALU_SUB=4'h5, ALU_PASSA_SHL=4'h8, ALU_PASSA_SHR=4'h9, ALU_ADD_SHR=4'hD, ALU_SUB_SHL=4'hA, ALU_ADD_SHL=4'hE.
  - Mode encodings.
  - Sequencer state typedef.
- One sub-module, `alp_iter_cnt`: loadable down-counter with a `last_h` flag (counter=1) and a `zero_h` flag.

## Test plan
- Reset while in STEP of MUL count=8 → next cycle IDLE, `busy_h`=0, `alu_h`=`uc_alu_h`, no `done_h`.
- SHL, count=3 → `busy_h` high for 3 cycles, `alu_h`=4'h8 on each; `done_h` on cycle 4 after start; back to IDLE.
- MUL, count=4, `q_lsb_h` sequence 1,0,1,1 → `alu_h` = D,9,D,D; `q_shift_h`=1 for 4 cycles.
- DIV, count=2, `alu_msb_h` 1 then 0 → opcodes A, E, then FIX with `neg`=0 giving 4'h0; `q_bit_h` = 0,1; `done_h` 4 cycles after start.
- DIV ending with `neg`=1 → FIX opcode 4'h4; count=0 of any mode → `done_h` next cycle, `busy_h` never set.
- `start_h` held high throughout SHR count=2 → one run only, `done_h` pulses once. A new start is accepted only from IDLE, after DONE.

Source files
------------

// File: rtl/alp_iter_seq_pkg.sv
// Shared ALP definitions: slice opcodes, iteration modes and sequencer states.
package alp_iter_seq_pkg;

    localparam logic [3:0] ALU_PASSA     = 4'h0;
    localparam logic [3:0] ALU_ADD       = 4'h4;
    localparam logic [3:0] ALU_SUB       = 4'h5;
    localparam logic [3:0] ALU_PASSA_SHL = 4'h8;
    localparam logic [3:0] ALU_PASSA_SHR = 4'h9;
    localparam logic [3:0] ALU_SUB_SHL   = 4'hA;
    localparam logic [3:0] ALU_ADD_SHR   = 4'hD;
    localparam logic [3:0] ALU_ADD_SHL   = 4'hE;

    typedef enum logic [1:0] {
        MODE_SHL = 2'd0,
        MODE_SHR = 2'd1,
        MODE_MUL = 2'd2,
        MODE_DIV = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    function automatic logic is_passa(input logic [3:0] op);
        return (op == ALU_PASSA) || (op == ALU_PASSA_SHL) || (op == ALU_PASSA_SHR);
    endfunction

endpackage

// File: rtl/alp_iter_cnt.sv
// Loadable iteration down-counter; holds at zero rather than wrapping.
module alp_iter_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             load_h,
    input  logic [CNT_W-1:0] load_val_h,
    input  logic             dec_h,
    output logic             last_h,
    output logic             zero_h
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            cnt <= '0;
        end else if (load_h) begin
            cnt <= load_val_h;
        end else if (dec_h && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last_h = (cnt == CNT_W'(1));
    assign zero_h = (cnt == '0);

endmodule

// File: rtl/alp_iter_seq.sv
// Iteration sequencer: owns the ALP slice controls for N shift/multiply/divide
// steps, otherwise passes microcode control straight through.
module alp_iter_seq
    import alp_iter_seq_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             start_h,
    input  logic [1:0]       mode_h,
    input  logic [CNT_W-1:0] count_h,
    input  logic [3:0]       uc_alu_h,
    input  logic             uc_pass_a_h,
    input  logic             uc_dmove_h,
    input  logic             q_lsb_h,
    input  logic             alu_msb_h,
    output logic [3:0]       alu_h,
    output logic             pass_a_h,
    output logic             dmove_h,
    output logic             shl_fill_h,
    output logic             shr_fill_h,
    output logic             q_shift_h,
    output logic             q_bit_h,
    output logic             busy_h,
    output logic             done_h
);

    seq_state_t state;
    mode_t      mode;
    logic       neg;
    logic       sign;
    logic       busy;
    logic       done;
    logic       last_h;
    logic       zero_h;
    logic [3:0] op;

    alp_iter_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset_l    (reset_l),
        .load_h     ((state == ST_IDLE) && start_h),
        .load_val_h (count_h),
        .dec_h      (state == ST_STEP),
        .last_h     (last_h),
        .zero_h     (zero_h)
    );

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state <= ST_IDLE;
            mode  <= MODE_SHL;
            neg   <= 1'b0;
            sign  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start_h) begin
                        mode <= mode_t'(mode_h);
                        neg  <= 1'b0;
                        // Operand sign for arithmetic right shift, held for the whole run
                        sign <= alu_msb_h;
                        if (count_h == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_STEP;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    if (mode == MODE_DIV) neg <= alu_msb_h;
                    if (last_h || zero_h) begin
                        if (mode == MODE_DIV) begin
                            state <= ST_FIX;
                        end else begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_FIX: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        op         = ALU_PASSA;
        alu_h      = uc_alu_h;
        pass_a_h   = uc_pass_a_h;
        dmove_h    = uc_dmove_h;
        shl_fill_h = 1'b0;
        shr_fill_h = 1'b0;
        q_shift_h  = 1'b0;
        q_bit_h    = 1'b0;
        if (state == ST_STEP) begin
            case (mode)
                MODE_SHL: op = ALU_PASSA_SHL;
                MODE_SHR: begin
                    op         = ALU_PASSA_SHR;
                    shr_fill_h = sign;
                end
                MODE_MUL: begin
                    op         = q_lsb_h ? ALU_ADD_SHR : ALU_PASSA_SHR;
                    // On an add-shift the top slice's shift-out carries the adder carry
                    shr_fill_h = q_lsb_h & alu_msb_h;
                    q_shift_h  = 1'b1;
                end
                default: begin
                    op        = neg ? ALU_ADD_SHL : ALU_SUB_SHL;
                    q_bit_h   = ~alu_msb_h;
                    q_shift_h = 1'b1;
                end
            endcase
        end else if (state == ST_FIX) begin
            op = neg ? ALU_ADD : ALU_PASSA;
        end
        if ((state == ST_STEP) || (state == ST_FIX)) begin
            alu_h    = op;
            pass_a_h = is_passa(op);
            dmove_h  = 1'b0;
        end
    end

    assign busy_h = busy;
    assign done_h = done;

endmodule

// File: tb/tb_alp_iter_seq.sv
// Directed bench for alp_iter_seq: reset, each mode, DIV fix-up, zero count, held start.
module tb_alp_iter_seq;

    logic       clk = 1'b0;
    logic       reset_l;
    logic       start_h;
    logic [1:0] mode_h;
    logic [5:0] count_h;
    logic [3:0] uc_alu_h;
    logic       uc_pass_a_h;
    logic       uc_dmove_h;
    logic       q_lsb_h;
    logic       alu_msb_h;
    logic [3:0] alu_h;
    logic       pass_a_h;
    logic       dmove_h;
    logic       shl_fill_h;
    logic       shr_fill_h;
    logic       q_shift_h;
    logic       q_bit_h;
    logic       busy_h;
    logic       done_h;

    int checks = 0;
    int errors = 0;

    alp_iter_seq #(.CNT_W(6)) dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .start_h     (start_h),
        .mode_h      (mode_h),
        .count_h     (count_h),
        .uc_alu_h    (uc_alu_h),
        .uc_pass_a_h (uc_pass_a_h),
        .uc_dmove_h  (uc_dmove_h),
        .q_lsb_h     (q_lsb_h),
        .alu_msb_h   (alu_msb_h),
        .alu_h       (alu_h),
        .pass_a_h    (pass_a_h),
        .dmove_h     (dmove_h),
        .shl_fill_h  (shl_fill_h),
        .shr_fill_h  (shr_fill_h),
        .q_shift_h   (q_shift_h),
        .q_bit_h     (q_bit_h),
        .busy_h      (busy_h),
        .done_h      (done_h)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        cyc();
        #1;
        checks++; if (busy_h !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_h); end
        checks++; if (done_h !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done_h); end
        checks++; if (alu_h !== 4'h3) begin errors++; $display("FAIL rst_alu got %h want 3", alu_h); end
        checks++; if (dmove_h !== 1'b1) begin errors++; $display("FAIL rst_dmove got %b want 1", dmove_h); end
        reset_l = 1'b1;
        // MUL count=8, abort by reset during STEP
        start_h = 1'b1; mode_h = 2'd2; count_h = 6'd8; q_lsb_h = 1'b1;
        cyc();
        start_h = 1'b0;
        #1;
        checks++; if (busy_h !== 1'b1 || alu_h !== 4'hD) begin errors++; $display("FAIL mulrst_step busy %b alu %h want 1 D", busy_h, alu_h); end
        cyc();
        reset_l = 1'b0;
        cyc();
        reset_l = 1'b1;
        #1;
        checks++; if (busy_h !== 1'b0 || alu_h !== 4'h3 || done_h !== 1'b0) begin errors++; $display("FAIL mulrst_abort busy %b alu %h done %b want 0 3 0", busy_h, alu_h, done_h); end
        cyc();
        #1;
        checks++; if (done_h !== 1'b0 || busy_h !== 1'b0 || pass_a_h !== 1'b1) begin errors++; $display("FAIL mulrst_after done %b busy %b pass_a %b want 0 0 1", done_h, busy_h, pass_a_h); end
    endtask

    task automatic test_shl();
        start_h = 1'b1; mode_h = 2'd0; count_h = 6'd3;
        cyc();
        start_h = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (busy_h !== 1'b1 || alu_h !== 4'h8 || pass_a_h !== 1'b1 || dmove_h !== 1'b0 || done_h !== 1'b0 || shl_fill_h !== 1'b0)
            begin errors++; $display("FAIL shl_step%0d busy %b alu %h pass %b dmove %b done %b fill %b want 1 8 1 0 0 0", i, busy_h, alu_h, pass_a_h, dmove_h, done_h, shl_fill_h); end
            cyc();
        end
        #1;
        checks++; if (done_h !== 1'b1 || busy_h !== 1'b0 || alu_h !== 4'h3) begin errors++; $display("FAIL shl_done done %b busy %b alu %h want 1 0 3", done_h, busy_h, alu_h); end
        cyc();
        #1;
        checks++; if (done_h !== 1'b0 || busy_h !== 1'b0) begin errors++; $display("FAIL shl_idle done %b busy %b want 0 0", done_h, busy_h); end
    endtask

    task automatic test_mul();
        logic       qs [4];
        logic [3:0] ex [4];
        qs = '{1'b1, 1'b0, 1'b1, 1'b1};
        ex = '{4'hD, 4'h9, 4'hD, 4'hD};
        alu_msb_h = 1'b0;
        start_h = 1'b1; mode_h = 2'd2; count_h = 6'd4;
        cyc();
        start_h = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q_lsb_h = qs[i];
            #1;
            checks++;
            if (alu_h !== ex[i] || q_shift_h !== 1'b1 || busy_h !== 1'b1 || pass_a_h !== (ex[i] == 4'h9))
            begin errors++; $display("FAIL mul_step%0d alu %h qshift %b busy %b pass %b want %h 1 1 %b", i, alu_h, q_shift_h, busy_h, pass_a_h, ex[i], (ex[i] == 4'h9)); end
            cyc();
        end
        #1;
        checks++; if (done_h !== 1'b1 || q_shift_h !== 1'b0) begin errors++; $display("FAIL mul_done done %b qshift %b want 1 0", done_h, q_shift_h); end
        cyc();
    endtask

    task automatic test_div();
        start_h = 1'b1; mode_h = 2'd3; count_h = 6'd2;
        cyc();
        start_h = 1'b0;
        alu_msb_h = 1'b1;
        #1;
        checks++; if (alu_h !== 4'hA || q_bit_h !== 1'b0 || q_shift_h !== 1'b1) begin errors++; $display("FAIL div_s0 alu %h qbit %b qshift %b want A 0 1", alu_h, q_bit_h, q_shift_h); end
        cyc();
        alu_msb_h = 1'b0;
        #1;
        checks++; if (alu_h !== 4'hE || q_bit_h !== 1'b1 || q_shift_h !== 1'b1) begin errors++; $display("FAIL div_s1 alu %h qbit %b qshift %b want E 1 1", alu_h, q_bit_h, q_shift_h); end
        cyc();
        #1;
        checks++; if (alu_h !== 4'h0 || q_shift_h !== 1'b0 || busy_h !== 1'b1 || pass_a_h !== 1'b1 || done_h !== 1'b0) begin errors++; $display("FAIL div_fix0 alu %h qshift %b busy %b pass %b done %b want 0 0 1 1 0", alu_h, q_shift_h, busy_h, pass_a_h, done_h); end
        cyc();
        #1;
        checks++; if (done_h !== 1'b1 || busy_h !== 1'b0) begin errors++; $display("FAIL div_done done %b busy %b want 1 0", done_h, busy_h); end
        cyc();
        // Single step ending negative: fix-up restores with ADD
        start_h = 1'b1; mode_h = 2'd3; count_h = 6'd1;
        cyc();
        start_h = 1'b0;
        alu_msb_h = 1'b1;
        #1;
        checks++; if (alu_h !== 4'hA || q_bit_h !== 1'b0) begin errors++; $display("FAIL divn_s0 alu %h qbit %b want A 0", alu_h, q_bit_h); end
        cyc();
        alu_msb_h = 1'b0;
        #1;
        checks++; if (alu_h !== 4'h4 || pass_a_h !== 1'b0 || q_shift_h !== 1'b0) begin errors++; $display("FAIL divn_fix alu %h pass %b qshift %b want 4 0 0", alu_h, pass_a_h, q_shift_h); end
        cyc();
        #1;
        checks++; if (done_h !== 1'b1) begin errors++; $display("FAIL divn_done done %b want 1", done_h); end
        cyc();
    endtask

    task automatic test_zero_count();
        for (int m = 0; m < 4; m++) begin
            start_h = 1'b1; mode_h = 2'(m); count_h = 6'd0;
            cyc();
            start_h = 1'b0;
            #1;
            checks++; if (done_h !== 1'b1 || busy_h !== 1'b0 || alu_h !== 4'h3) begin errors++; $display("FAIL zero_m%0d done %b busy %b alu %h want 1 0 3", m, done_h, busy_h, alu_h); end
            cyc();
            #1;
            checks++; if (done_h !== 1'b0 || busy_h !== 1'b0) begin errors++; $display("FAIL zero_idle_m%0d done %b busy %b want 0 0", m, done_h, busy_h); end
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        alu_msb_h = 1'b1;
        start_h = 1'b1; mode_h = 2'd1; count_h = 6'd2;
        cyc();
        alu_msb_h = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (alu_h !== 4'h9 || shr_fill_h !== 1'b1 || busy_h !== 1'b1) begin errors++; $display("FAIL shr_step%0d alu %h fill %b busy %b want 9 1 1", i, alu_h, shr_fill_h, busy_h); end
            if (done_h === 1'b1) dones++;
            cyc();
        end
        #1;
        if (done_h === 1'b1) dones++;
        cyc();
        #1;
        if (done_h === 1'b1) dones++;
        checks++; if (busy_h !== 1'b0) begin errors++; $display("FAIL shr_idle busy %b want 0", busy_h); end
        start_h = 1'b0;
        cyc();
        #1;
        if (done_h === 1'b1) dones++;
        checks++; if (dones !== 1) begin errors++; $display("FAIL shr_done_pulses got %0d want 1", dones); end
        checks++; if (busy_h !== 1'b0) begin errors++; $display("FAIL shr_norestart busy %b want 0", busy_h); end
        // Fresh start from IDLE is accepted
        start_h = 1'b1; mode_h = 2'd0; count_h = 6'd1;
        cyc();
        start_h = 1'b0;
        #1;
        checks++; if (busy_h !== 1'b1 || alu_h !== 4'h8 || shr_fill_h !== 1'b0) begin errors++; $display("FAIL restart busy %b alu %h fill %b want 1 8 0", busy_h, alu_h, shr_fill_h); end
        cyc();
        #1;
        checks++; if (done_h !== 1'b1) begin errors++; $display("FAIL restart_done done %b want 1", done_h); end
        cyc();
    endtask

    initial begin
        reset_l = 1'b0; start_h = 1'b0; mode_h = 2'd0; count_h = 6'd0;
        uc_alu_h = 4'h3; uc_pass_a_h = 1'b1; uc_dmove_h = 1'b1;
        q_lsb_h = 1'b0; alu_msb_h = 1'b0;
        cyc();
        test_reset();
        test_shl();
        test_mul();
        test_div();
        test_zero_count();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
